rgb_fade_sequencer: RTL and testbench

//  Autonomous colour-show controller for the RGB mixer PWM datapath. Stores NKEY keyframes
//  (R,G,B level + hold time), ramps three WIDTH-bit PWM duty levels linearly toward each

---
 rtl/rgb_seq_pkg.sv | 35 +++
 rtl/rgb_tick_div.sv | 34 +++
 rtl/rgb_fade_sequencer.sv | 174 +++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
`default_nettype none
// ============================================================================
// rgb_seq_pkg : shared types and register-field layout for the RGB fade
//               sequencer (sequencer states, keyframe and CTRL bit fields).
// Revision    : 1.0
// ============================================================================
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    localparam int NCHAN       = 3;
    localparam int KF_FIELD_W  = 8;
    localparam int KF_HOLD_LSB = 24;
    localparam int KF_R_LSB    = 16;
    localparam int KF_G_LSB    = 8;
    localparam int KF_B_LSB    = 0;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LAST_LSB = 1;

    // Channel 0 = red, 1 = green, 2 = blue.
    function automatic int kf_chan_lsb(input int chan);
        case (chan)
            0:       return KF_R_LSB;
            1:       return KF_G_LSB;
            default: return KF_B_LSB;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_tick_div.sv
`default_nettype none
// ============================================================================
// rgb_tick_div : prescaler emitting a one-cycle tick every TICK_DIV cycles
//                while run is high; parked at zero otherwise.
// Revision     : 1.0
// ============================================================================
module rgb_tick_div #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == TERMINAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// rgb_fade_sequencer : keyframe colour-show engine ramping three PWM levels
//                      toward stored keyframes, dwelling, then advancing.
// Revision           : 1.0
// ============================================================================
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NKEY     = 4,
    parameter int TICK_DIV = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_we,
    input  logic [$clog2(NKEY):0]     cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic                      cfg_ack,
    output logic [WIDTH-1:0]          level_r,
    output logic [WIDTH-1:0]          level_g,
    output logic [WIDTH-1:0]          level_b,
    output logic                      level_upd,
    output logic [$clog2(NKEY)-1:0]   key_idx,
    output logic                      busy
);

    localparam int KA = $clog2(NKEY);

    seq_state_t state_q, state_d;

    logic [KF_FIELD_W-1:0] kf_hold [NKEY];
    logic [KF_FIELD_W-1:0] kf_lvl  [NKEY][NCHAN];
    logic                  ctrl_en;
    logic [KA-1:0]         ctrl_last;

    logic [KF_FIELD_W-1:0] hold_cnt;
    logic                  tick;
    logic                  step_en;
    logic                  enter_hold;
    logic                  hold_dec;
    logic                  advance;
    logic [NCHAN-1:0]      at_target;
    logic [NCHAN-1:0]      moved;
    logic [NCHAN-1:0][WIDTH-1:0] levels;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NKEY; k++) begin
                kf_hold[k] <= '0;
                for (int c = 0; c < NCHAN; c++) begin
                    kf_lvl[k][c] <= '0;
                end
            end
            ctrl_en   <= 1'b0;
            ctrl_last <= '0;
        end else if (cfg_we) begin
            if (cfg_addr[KA]) begin
                ctrl_en   <= cfg_wdata[CTRL_EN_BIT];
                ctrl_last <= cfg_wdata[CTRL_LAST_LSB +: KA];
            end else begin
                kf_hold[cfg_addr[KA-1:0]] <= cfg_wdata[KF_HOLD_LSB +: KF_FIELD_W];
                for (int c = 0; c < NCHAN; c++) begin
                    kf_lvl[cfg_addr[KA-1:0]][c] <= cfg_wdata[kf_chan_lsb(c) +: KF_FIELD_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_we;
        end
    end

    // Dropping en clears the prescaler in the same cycle the FSM heads to IDLE.
    rgb_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (ctrl_en && (state_q != IDLE)),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ctrl_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RAMP;
                RAMP:    if (&at_target) state_d = HOLD;
                HOLD:    if (tick && (hold_cnt == '0)) state_d = RAMP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        step_en    = 1'b0;
        enter_hold = 1'b0;
        hold_dec   = 1'b0;
        advance    = 1'b0;
        case (state_q)
            RAMP: begin
                step_en    = tick;
                enter_hold = ctrl_en && (&at_target);
            end
            HOLD: begin
                advance  = tick && (hold_cnt == '0);
                hold_dec = tick && (hold_cnt != '0);
            end
            default: ;
        endcase
    end

    // Targets are read live from the keyframe slot, so a rewrite retargets at once.
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] level_q;

        assign target       = WIDTH'(kf_lvl[key_idx][c]);
        assign at_target[c] = (level_q == target);
        assign moved[c]     = step_en && !at_target[c];
        assign levels[c]    = level_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q <= '0;
            end else if (moved[c]) begin
                level_q <= (level_q < target) ? level_q + 1'b1 : level_q - 1'b1;
            end
        end
    end

    assign level_r = levels[0];
    assign level_g = levels[1];
    assign level_b = levels[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_idx   <= '0;
            hold_cnt  <= '0;
            level_upd <= 1'b0;
        end else begin
            level_upd <= |moved;
            if (!ctrl_en) begin
                key_idx <= '0;
            end else if (advance) begin
                // >= so that shrinking last below the active slot still wraps to 0.
                key_idx <= (key_idx >= ctrl_last) ? '0 : key_idx + 1'b1;
            end
            if (enter_hold) begin
                hold_cnt <= kf_hold[key_idx];
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rgb_fade_sequencer : directed + randomized bench with a behavioural model.
// Revision              : 1.0
// ============================================================================
module tb_rgb_fade_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_ack;
    logic [7:0]  level_r, level_g, level_b;
    logic        level_upd;
    logic [1:0]  key_idx;
    logic        busy;

    rgb_fade_sequencer #(
        .WIDTH    (8),
        .NKEY     (4),
        .TICK_DIV (TD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ack   (cfg_ack),
        .level_r   (level_r),
        .level_g   (level_g),
        .level_b   (level_b),
        .level_upd (level_upd),
        .key_idx   (key_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: observable show state advanced once per clock.
    typedef struct packed {
        logic            en;
        logic [1:0]      last;
        logic            running;
        logic            dwelling;
        logic [1:0]      phase;
        logic [1:0]      key;
        logic [7:0]      dwell_left;
        logic            ack;
        logic            upd;
        logic [2:0][7:0] lvl;
    } mstate_t;

    mstate_t    m;
    logic [7:0] m_kfl [4][3];
    logic [7:0] m_kfh [4];

    function automatic mstate_t model_next(input mstate_t s, input logic we,
                                           input logic [2:0] a, input logic [31:0] d);
        mstate_t n;
        logic    tick;
        logic    arrived;
        n = s;
        tick = s.running && s.en && (int'(s.phase) == TD - 1);
        n.ack = we;
        n.upd = 1'b0;
        if (!s.en) begin
            n.running = 1'b0; n.dwelling = 1'b0; n.key = 2'd0; n.phase = 2'd0;
        end else if (!s.running) begin
            n.running = 1'b1; n.dwelling = 1'b0; n.phase = 2'd0;
        end else begin
            n.phase = tick ? 2'd0 : s.phase + 2'd1;
            if (!s.dwelling) begin
                arrived = 1'b1;
                for (int c = 0; c < 3; c++)
                    if (s.lvl[c] != m_kfl[s.key][c]) arrived = 1'b0;
                if (arrived) begin
                    n.dwelling = 1'b1;
                    n.dwell_left = m_kfh[s.key];
                end else if (tick) begin
                    n.upd = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        if (s.lvl[c] < m_kfl[s.key][c]) n.lvl[c] = s.lvl[c] + 8'd1;
                        else if (s.lvl[c] > m_kfl[s.key][c]) n.lvl[c] = s.lvl[c] - 8'd1;
                    end
                end
            end else if (tick) begin
                if (s.dwell_left == 8'd0) begin
                    n.dwelling = 1'b0;
                    n.key = (s.key >= s.last) ? 2'd0 : s.key + 2'd1;
                end else begin
                    n.dwell_left = s.dwell_left - 8'd1;
                end
            end
        end
        if (we && a[2]) begin
            n.en = d[0];
            n.last = d[2:1];
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
            for (int k = 0; k < 4; k++) begin
                m_kfh[k] <= 8'd0;
                for (int c = 0; c < 3; c++) m_kfl[k][c] <= 8'd0;
            end
        end else begin
            m <= model_next(m, cfg_we, cfg_addr, cfg_wdata);
            if (cfg_we && !cfg_addr[2]) begin
                m_kfh[cfg_addr[1:0]]    <= cfg_wdata[31:24];
                m_kfl[cfg_addr[1:0]][0] <= cfg_wdata[23:16];
                m_kfl[cfg_addr[1:0]][1] <= cfg_wdata[15:8];
                m_kfl[cfg_addr[1:0]][2] <= cfg_wdata[7:0];
            end
        end
    end

    always @(negedge clk) begin
        chk("level_r", level_r, m.lvl[0]);
        chk("level_g", level_g, m.lvl[1]);
        chk("level_b", level_b, m.lvl[2]);
        chk("key_idx", key_idx, m.key);
        chk("busy", busy, m.running);
        chk("cfg_ack", cfg_ack, m.ack);
        chk("level_upd", level_upd, m.upd);
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    function automatic logic [31:0] kf(input int h, input int r, input int g, input int b);
        return {8'(h), 8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_level_r", level_r, 0);
        chk("rst_level_g", level_g, 0);
        chk("rst_level_b", level_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_idx", key_idx, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_level_upd", level_upd, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] h, r, g, b;
        #3 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset taken mid-ramp
        wr(3'd0, kf(0, 50, 0, 0));
        wr(3'd4, 32'd1);
        repeat (11) @(negedge clk);
        chk("t1_pre_reset_r", level_r, 2);
        chk("t1_pre_reset_busy", busy, 1);
        do_reset();

        // Static colour, slot 0 loops
        wr(3'd0, kf(2, 3, 0, 1));
        wr(3'd4, 32'd1);
        repeat (5) @(negedge clk);
        chk("t2_tick1_r", level_r, 1);
        chk("t2_tick1_b", level_b, 1);
        repeat (4) @(negedge clk);
        chk("t2_tick2_r", level_r, 2);
        repeat (4) @(negedge clk);
        chk("t2_tick3_r", level_r, 3);
        repeat (60) @(negedge clk);
        chk("t2_final_r", level_r, 3);
        chk("t2_final_g", level_g, 0);
        chk("t2_final_b", level_b, 1);
        chk("t2_final_key", key_idx, 0);
        do_reset();

        // Two-slot show
        wr(3'd0, kf(0, 5, 5, 5));
        wr(3'd1, kf(0, 2, 8, 5));
        wr(3'd4, 32'd3);
        n = 0;
        while (key_idx != 2'd1 && n < 200) begin @(negedge clk); n++; end
        chk("t3_reach_kf1", key_idx, 1);
        n = 0;
        while (!(level_r == 8'd2 && level_g == 8'd8 && level_b == 8'd5) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t3_kf1_ramp_cycles", n, 12);
        n = 0;
        while (key_idx != 2'd0 && n < 100) begin @(negedge clk); n++; end
        chk("t3_back_to_kf0", key_idx, 0);
        n = 0;
        while (!(level_r == 8'd5 && level_g == 8'd5) && n < 100) begin @(negedge clk); n++; end
        chk("t3_kf0_again_r", level_r, 5);
        do_reset();

        // Retarget the active slot mid-ramp
        wr(3'd0, kf(0, 10, 0, 0));
        wr(3'd4, 32'd1);
        n = 0;
        while (level_r != 8'd6 && n < 100) begin @(negedge clk); n++; end
        chk("t4_reach_6", level_r, 6);
        wr(3'd0, kf(0, 4, 0, 0));
        repeat (40) @(negedge clk);
        chk("t4_settled_r", level_r, 4);
        chk("t4_busy", busy, 1);
        do_reset();

        // Disable during dwell, re-enable
        wr(3'd0, kf(5, 2, 0, 0));
        wr(3'd4, 32'd1);
        n = 0;
        while (level_r != 8'd2 && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        wr(3'd4, 32'd0);
        @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_key", key_idx, 0);
        chk("t5_frozen_r", level_r, 2);
        wr(3'd0, kf(0, 5, 0, 0));
        wr(3'd4, 32'd1);
        repeat (4) @(negedge clk);
        chk("t5_before_first_tick", level_r, 2);
        @(negedge clk);
        chk("t5_first_tick", level_r, 3);
        do_reset();

        // Shrinking last below the active slot
        wr(3'd0, kf(0, 1, 0, 0));
        wr(3'd1, kf(0, 2, 0, 0));
        wr(3'd2, kf(3, 3, 0, 0));
        wr(3'd3, kf(0, 4, 0, 0));
        wr(3'd4, 32'd7);
        n = 0;
        while (key_idx != 2'd2 && n < 300) begin @(negedge clk); n++; end
        chk("t6_reach_kf2", key_idx, 2);
        wr(3'd4, 32'd3);
        n = 0;
        while (key_idx == 2'd2 && n < 100) begin @(negedge clk); n++; end
        chk("t6_wrap_to_0", key_idx, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 199);
            if (sel < 8) begin
                h = 8'($urandom_range(0, 3));
                r = 8'($urandom_range(0, 12));
                g = 8'($urandom_range(0, 12));
                b = 8'($urandom_range(0, 12));
                wr({1'b0, 2'($urandom_range(0, 3))}, {h, r, g, b});
            end else if (sel < 12) begin
                wr(3'd4, {29'd0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) != 0)});
            end else if (sel == 12) begin
                do_reset();
            end else begin
                @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
